// File: rtl/rs422_multi_echo.sv
// rs422_multi_echo: N-channel RS422 UART echo engine.
// Each channel: 2-FF RX synchroniser, mid-bit sampling receiver, echo FIFO,
// transmitter with frame-start hold, and sticky frame/overflow/parity flags.
// Optional even-parity framing is enabled by defining RS422_PARITY_EN;
// without it frames are 10 bits and parity_err is tied low.
//
// RX FSM
//   state        | meaning
//   RX_IDLE      | line idle, waiting for a 1->0 transition
//   RX_START     | counting to the start-bit centre, rejects glitches
//   RX_DATA      | sampling D0..D7, LSB first
//   RX_PARITY    | sampling the even-parity bit (parity build only)
//   RX_STOP      | sampling the stop bit, pushes the byte if valid
//   RX_WAIT      | framing error seen, waiting for the line to go high
// TX FSM
//   state        | meaning
//   TX_IDLE      | waiting for FIFO data with tx_hold low
//   TX_START     | start bit
//   TX_DATA      | D0..D7, LSB first
//   TX_PARITY    | even-parity bit (parity build only)
//   TX_STOP      | stop bit, may chain straight into the next frame
module rs422_multi_echo #(
    parameter int NUM_CH     = 2,
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] rs422_rx,
    output logic [NUM_CH-1:0] rs422_tx,
    input  logic [NUM_CH-1:0] tx_hold,
    input  logic              clr_status,
    output logic [NUM_CH-1:0] frame_err,
    output logic [NUM_CH-1:0] overflow,
    output logic [NUM_CH-1:0] parity_err
);

    localparam int CPB = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(CPB);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

`ifndef RS422_PARITY_EN
    assign parity_err = '0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [1:0]    r_sync;
        logic          r_rx_prev;
        logic          w_rx;
        rx_state_t     r_rx_state;
        logic [CW-1:0] r_rx_cnt;
        logic [2:0]    r_rx_bit;
        logic [7:0]    r_rx_shift;
        logic          w_stop_ok;
        logic          w_stop_bad;
        logic          w_wr;
        logic          r_frame_err;
        logic          r_overflow;

        logic [7:0]    r_mem [FIFO_DEPTH];
        logic [AW:0]   r_wptr;
        logic [AW:0]   r_rptr;
        logic          w_empty;
        logic          w_full;
        logic          w_rd;
        logic          w_push;
        logic          w_drop;
        logic [7:0]    w_head;

        tx_state_t     r_tx_state;
        logic [CW-1:0] r_tx_cnt;
        logic [2:0]    r_tx_bit;
        logic [7:0]    r_tx_shift;
        logic          r_tx;
        logic          w_tx_bit;

        assign w_rx = r_sync[1];

        // Two-flop synchroniser plus previous synchronised value for edge detect
        always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync    <= 2'b11;
                r_rx_prev <= 1'b1;
            end else begin
                r_sync    <= {r_sync[0], rs422_rx[g]};
                r_rx_prev <= w_rx;
            end
        end

        assign w_stop_ok  = (r_rx_state == RX_STOP) && (r_rx_cnt == '0) && w_rx;
        assign w_stop_bad = (r_rx_state == RX_STOP) && (r_rx_cnt == '0) && !w_rx;

`ifdef RS422_PARITY_EN
        logic r_rx_pbit;
        logic w_par_ok;
        logic r_parity_err;
        logic r_tx_par;

        assign w_par_ok = ~(^{r_rx_shift, r_rx_pbit});
        assign w_wr     = w_stop_ok && w_par_ok;

        // Captures the received parity bit at its centre
        always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n)
                r_rx_pbit <= 1'b0;
            else if ((r_rx_state == RX_PARITY) && (r_rx_cnt == '0))
                r_rx_pbit <= w_rx;
        end

        // Sticky parity error; a new event beats a simultaneous clear
        always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n)
                r_parity_err <= 1'b0;
            else if (w_stop_ok && !w_par_ok)
                r_parity_err <= 1'b1;
            else if (clr_status)
                r_parity_err <= 1'b0;
        end

        // Even parity of the byte being loaded for transmission
        always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n)
                r_tx_par <= 1'b0;
            else if (w_rd)
                r_tx_par <= ^w_head;
        end

        assign parity_err[g] = r_parity_err;
`else
        assign w_wr = w_stop_ok;
`endif

        // Receiver: half-bit to start centre, then one bit period per sample
        always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rx_state <= RX_IDLE;
                r_rx_cnt   <= '0;
                r_rx_bit   <= '0;
                r_rx_shift <= '0;
            end else begin
                case (r_rx_state)
                    RX_IDLE: begin
                        if (r_rx_prev && !w_rx) begin
                            r_rx_state <= RX_START;
                            r_rx_cnt   <= HALF_M1;
                            r_rx_bit   <= '0;
                        end
                    end
                    RX_START: begin
                        if (r_rx_cnt == '0) begin
                            if (w_rx) begin
                                r_rx_state <= RX_IDLE;
                            end else begin
                                r_rx_state <= RX_DATA;
                                r_rx_cnt   <= CPB_M1;
                            end
                        end else begin
                            r_rx_cnt <= r_rx_cnt - 1'b1;
                        end
                    end
                    RX_DATA: begin
                        if (r_rx_cnt == '0) begin
                            r_rx_shift <= {w_rx, r_rx_shift[7:1]};
                            r_rx_cnt   <= CPB_M1;
                            if (r_rx_bit == 3'd7) begin
`ifdef RS422_PARITY_EN
                                r_rx_state <= RX_PARITY;
`else
                                r_rx_state <= RX_STOP;
`endif
                            end else begin
                                r_rx_bit <= r_rx_bit + 1'b1;
                            end
                        end else begin
                            r_rx_cnt <= r_rx_cnt - 1'b1;
                        end
                    end
`ifdef RS422_PARITY_EN
                    RX_PARITY: begin
                        if (r_rx_cnt == '0) begin
                            r_rx_state <= RX_STOP;
                            r_rx_cnt   <= CPB_M1;
                        end else begin
                            r_rx_cnt <= r_rx_cnt - 1'b1;
                        end
                    end
`endif
                    RX_STOP: begin
                        if (r_rx_cnt == '0)
                            r_rx_state <= w_rx ? RX_IDLE : RX_WAIT;
                        else
                            r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                    RX_WAIT: begin
                        if (w_rx)
                            r_rx_state <= RX_IDLE;
                    end
                    default: r_rx_state <= RX_IDLE;
                endcase
            end
        end

        assign w_empty = (r_wptr == r_rptr);
        assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
        assign w_push  = w_wr && (!w_full || w_rd);
        assign w_drop  = w_wr && w_full && !w_rd;
        assign w_head  = r_mem[r_rptr[AW-1:0]];

        // FIFO storage; the head is read before a same-edge write can replace it
        always_ff @(posedge sys_clk) begin
            if (w_push)
                r_mem[r_wptr[AW-1:0]] <= r_rx_shift;
        end

        // FIFO pointers with wrap bit
        always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push)
                    r_wptr <= r_wptr + 1'b1;
                if (w_rd)
                    r_rptr <= r_rptr + 1'b1;
            end
        end

        // Sticky frame and overflow flags; a new event beats a simultaneous clear
        always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n) begin
                r_frame_err <= 1'b0;
                r_overflow  <= 1'b0;
            end else begin
                if (w_stop_bad)
                    r_frame_err <= 1'b1;
                else if (clr_status)
                    r_frame_err <= 1'b0;
                if (w_drop)
                    r_overflow <= 1'b1;
                else if (clr_status)
                    r_overflow <= 1'b0;
            end
        end

        // Pop when idle, or at the end of a stop bit for gapless back-to-back frames
        assign w_rd = !w_empty && !tx_hold[g] &&
                      ((r_tx_state == TX_IDLE) ||
                       ((r_tx_state == TX_STOP) && (r_tx_cnt == '0)));

        // Line level for the current TX state; registered one cycle later
        always_comb begin
            w_tx_bit = 1'b1;
            case (r_tx_state)
                TX_START:  w_tx_bit = 1'b0;
                TX_DATA:   w_tx_bit = r_tx_shift[0];
`ifdef RS422_PARITY_EN
                TX_PARITY: w_tx_bit = r_tx_par;
`endif
                default:   w_tx_bit = 1'b1;
            endcase
        end

        // Transmitter: each state lasts exactly one bit period
        always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n) begin
                r_tx_state <= TX_IDLE;
                r_tx_cnt   <= '0;
                r_tx_bit   <= '0;
                r_tx_shift <= '0;
                r_tx       <= 1'b1;
            end else begin
                r_tx <= w_tx_bit;
                case (r_tx_state)
                    TX_IDLE: begin
                        if (w_rd) begin
                            r_tx_shift <= w_head;
                            r_tx_cnt   <= CPB_M1;
                            r_tx_state <= TX_START;
                        end
                    end
                    TX_START: begin
                        if (r_tx_cnt == '0) begin
                            r_tx_cnt   <= CPB_M1;
                            r_tx_bit   <= '0;
                            r_tx_state <= TX_DATA;
                        end else begin
                            r_tx_cnt <= r_tx_cnt - 1'b1;
                        end
                    end
                    TX_DATA: begin
                        if (r_tx_cnt == '0) begin
                            r_tx_cnt   <= CPB_M1;
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            if (r_tx_bit == 3'd7) begin
`ifdef RS422_PARITY_EN
                                r_tx_state <= TX_PARITY;
`else
                                r_tx_state <= TX_STOP;
`endif
                            end else begin
                                r_tx_bit <= r_tx_bit + 1'b1;
                            end
                        end else begin
                            r_tx_cnt <= r_tx_cnt - 1'b1;
                        end
                    end
`ifdef RS422_PARITY_EN
                    TX_PARITY: begin
                        if (r_tx_cnt == '0) begin
                            r_tx_cnt   <= CPB_M1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx_cnt <= r_tx_cnt - 1'b1;
                        end
                    end
`endif
                    TX_STOP: begin
                        if (r_tx_cnt == '0) begin
                            if (w_rd) begin
                                r_tx_shift <= w_head;
                                r_tx_cnt   <= CPB_M1;
                                r_tx_state <= TX_START;
                            end else begin
                                r_tx_state <= TX_IDLE;
                            end
                        end else begin
                            r_tx_cnt <= r_tx_cnt - 1'b1;
                        end
                    end
                    default: r_tx_state <= TX_IDLE;
                endcase
            end
        end

        assign rs422_tx[g]  = r_tx;
        assign frame_err[g] = r_frame_err;
        assign overflow[g]  = r_overflow;
    end

endmodule
